// File: rtl/csr_access_ctrl_if.sv
// Request/response and CSR-file port bundle for csr_access_ctrl.
// The slave view is the controller; the master view is the execute stage plus CSR file.
interface csr_access_ctrl_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [2:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_src;
  logic [31:0]           req_pc;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_redirect;
  logic                  resp_err;

  logic [ADDR_WIDTH-1:0] csr_raddr;
  logic [DATA_WIDTH-1:0] csr_rdata;
  logic                  csr_wen;
  logic [ADDR_WIDTH-1:0] csr_waddr;
  logic [DATA_WIDTH-1:0] csr_wdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_src, req_pc, resp_ready, csr_rdata,
    output req_ready, resp_valid, resp_data, resp_redirect, resp_err,
           csr_raddr, csr_wen, csr_waddr, csr_wdata
  );

  modport master (
    output req_valid, req_op, req_addr, req_src, req_pc, resp_ready, csr_rdata,
    input  req_ready, resp_valid, resp_data, resp_redirect, resp_err,
           csr_raddr, csr_wen, csr_waddr, csr_wdata
  );
endinterface

// File: rtl/csr_access_ctrl.sv
// Sequences CSR instructions, ECALL and MRET into ordered single-port CSR file
// read/write cycles, with valid/ready handshakes on request and response.
//
// state      | meaning
// -----------+-------------------------------------------------------
// IDLE       | waiting for a request (req_ready=1 once out of reset)
// READ       | read target CSR (or mepc for MRET) into old_r
// WRITE      | write modified value back (suppressed for RS/RC with src==0)
// TRAP_CAUSE | ECALL: write ECALL_CAUSE to mcause
// TRAP_EPC   | ECALL: write latched pc to mepc
// TRAP_VEC   | ECALL: read mtvec into old_r
// RESP       | present response, hold until resp_ready
module csr_access_ctrl #(
  parameter int                    ADDR_WIDTH  = 12,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] MTVEC_ADDR  = 'h305,
  parameter logic [ADDR_WIDTH-1:0] MEPC_ADDR   = 'h341,
  parameter logic [ADDR_WIDTH-1:0] MCAUSE_ADDR = 'h342,
  parameter logic [DATA_WIDTH-1:0] ECALL_CAUSE = 'h0000000b
) (
  input  logic             clk,
  input  logic             rst,
  csr_access_ctrl_if.slave bus
);

  localparam logic [2:0] OP_RW    = 3'd0;
  localparam logic [2:0] OP_RS    = 3'd1;
  localparam logic [2:0] OP_RC    = 3'd2;
  localparam logic [2:0] OP_ECALL = 3'd3;
  localparam logic [2:0] OP_MRET  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_READ       = 3'd1,
    S_WRITE      = 3'd2,
    S_TRAP_CAUSE = 3'd3,
    S_TRAP_EPC   = 3'd4,
    S_TRAP_VEC   = 3'd5,
    S_RESP       = 3'd6
  } state_t;

  state_t                state, state_nxt;
  logic                  ready_r;
  logic [2:0]            op_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] src_r;
  logic [31:0]           pc_r;
  logic [DATA_WIDTH-1:0] old_r;
  logic                  accept;
  logic                  op_reserved;

  assign accept      = bus.req_valid && ready_r && (state == S_IDLE);
  assign op_reserved = (op_r > OP_MRET);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // ready_r is registered so it only rises on the first edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_r <= 1'b0;
      op_r    <= '0;
      addr_r  <= '0;
      src_r   <= '0;
      pc_r    <= '0;
      old_r   <= '0;
    end else begin
      ready_r <= (state_nxt == S_IDLE);
      if (accept) begin
        op_r   <= bus.req_op;
        addr_r <= bus.req_addr;
        src_r  <= bus.req_src;
        pc_r   <= bus.req_pc;
        old_r  <= '0;
      end else if (state == S_READ || state == S_TRAP_VEC) begin
        old_r <= bus.csr_rdata;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (accept) begin
          case (bus.req_op)
            OP_RW, OP_RS, OP_RC, OP_MRET: state_nxt = S_READ;
            OP_ECALL:                     state_nxt = S_TRAP_CAUSE;
            default:                      state_nxt = S_RESP;
          endcase
        end
      end
      S_READ:       state_nxt = (op_r == OP_MRET) ? S_RESP : S_WRITE;
      S_WRITE:      state_nxt = S_RESP;
      S_TRAP_CAUSE: state_nxt = S_TRAP_EPC;
      S_TRAP_EPC:   state_nxt = S_TRAP_VEC;
      S_TRAP_VEC:   state_nxt = S_RESP;
      S_RESP:       if (bus.resp_ready) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready     = ready_r;
    bus.resp_valid    = 1'b0;
    bus.resp_data     = '0;
    bus.resp_redirect = 1'b0;
    bus.resp_err      = 1'b0;
    bus.csr_raddr     = '0;
    bus.csr_wen       = 1'b0;
    bus.csr_waddr     = '0;
    bus.csr_wdata     = '0;
    unique case (state)
      S_READ: begin
        bus.csr_raddr = (op_r == OP_MRET) ? MEPC_ADDR : addr_r;
      end
      S_WRITE: begin
        bus.csr_waddr = addr_r;
        // Set/clear with a zero mask must not write, so read-only CSRs stay quiet.
        bus.csr_wen   = (op_r == OP_RW) || (src_r != '0);
        case (op_r)
          OP_RS:   bus.csr_wdata = old_r | src_r;
          OP_RC:   bus.csr_wdata = old_r & ~src_r;
          default: bus.csr_wdata = src_r;
        endcase
      end
      S_TRAP_CAUSE: begin
        bus.csr_wen   = 1'b1;
        bus.csr_waddr = MCAUSE_ADDR;
        bus.csr_wdata = ECALL_CAUSE;
      end
      S_TRAP_EPC: begin
        bus.csr_wen   = 1'b1;
        bus.csr_waddr = MEPC_ADDR;
        bus.csr_wdata = DATA_WIDTH'(pc_r);
      end
      S_TRAP_VEC: begin
        bus.csr_raddr = MTVEC_ADDR;
      end
      S_RESP: begin
        bus.resp_valid    = 1'b1;
        bus.resp_data     = old_r;
        bus.resp_redirect = (op_r == OP_ECALL) || (op_r == OP_MRET);
        bus.resp_err      = op_reserved;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Bench for csr_access_ctrl: a CSR file model behind the controller, directed
// scenarios, and randomized traffic checked against an array-based reference.
module tb_csr_access_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  csr_access_ctrl_if ifc();
  csr_access_ctrl dut (.clk(clk), .rst(rst), .bus(ifc));

  logic [31:0] mem  [4096];
  logic [31:0] refm [4096];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          wr_count = 0;

  assign ifc.csr_rdata = mem[ifc.csr_raddr];
  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (ifc.csr_wen) mem[ifc.csr_waddr] <= ifc.csr_wdata;
  end
  always @(posedge clk) if (ifc.csr_wen) wr_count <= wr_count + 1;

  int errors = 0;
  int checks = 0;

  int          obs_lat, obs_nw, obs_wc[4];
  logic [11:0] obs_wa[4];
  logic [31:0] obs_wd[4];
  logic [31:0] obs_data;
  logic        obs_redir, obs_err;
  bit          obs_ok;

  logic [11:0] addr_set [8] = '{12'h300, 12'h305, 12'h341, 12'h342,
                                12'h304, 12'h340, 12'h7C0, 12'hFFF};

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [11:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
    refm[a] = d;
  endtask

  // Drives one request and records everything up to the first resp_valid cycle.
  task automatic do_req(input logic [2:0] op, input logic [11:0] a,
                        input logic [31:0] s, input logic [31:0] p);
    int n;
    int cyc;
    obs_ok = 1'b0; obs_nw = 0; obs_lat = 0;
    @(negedge clk);
    ifc.req_valid = 1'b1; ifc.req_op = op; ifc.req_addr = a;
    ifc.req_src = s; ifc.req_pc = p;
    n = 0;
    while (!ifc.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!ifc.req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=0 after %0d cycles, need 1", n);
      ifc.req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Garbage on the request bus while busy must be ignored.
    ifc.req_op = 3'($urandom); ifc.req_addr = 12'($urandom);
    ifc.req_src = $urandom; ifc.req_pc = $urandom;
    cyc = 1;
    while (cyc <= 20) begin
      if (ifc.csr_wen && obs_nw < 4) begin
        obs_wc[obs_nw] = cyc; obs_wa[obs_nw] = ifc.csr_waddr;
        obs_wd[obs_nw] = ifc.csr_wdata; obs_nw++;
      end
      if (ifc.resp_valid) break;
      @(posedge clk); #1;
      cyc++;
    end
    ifc.req_valid = 1'b0;
    if (!ifc.resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: resp_valid=0 after %0d cycles, need 1", cyc);
      return;
    end
    obs_ok = 1'b1; obs_lat = cyc; obs_data = ifc.resp_data;
    obs_redir = ifc.resp_redirect; obs_err = ifc.resp_err;
  endtask

  task automatic ack(input int delay);
    repeat (delay) @(posedge clk);
    @(negedge clk); ifc.resp_ready = 1'b1;
    @(posedge clk); #1;
    ifc.resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    #1;
    checks++; if (ifc.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got=%0b need=0", ifc.req_ready); end
    checks++; if (ifc.resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got=%0b need=0", ifc.resp_valid); end
    checks++; if ({ifc.resp_redirect, ifc.resp_err, ifc.resp_data} !== 34'h0) begin errors++; $display("FAIL rst_resp_fields got redir=%0b err=%0b data=%0h need 0", ifc.resp_redirect, ifc.resp_err, ifc.resp_data); end
    checks++; if ({ifc.csr_wen, ifc.csr_raddr, ifc.csr_waddr, ifc.csr_wdata} !== 57'h0) begin errors++; $display("FAIL rst_csr_port got wen=%0b ra=%0h wa=%0h wd=%0h need 0", ifc.csr_wen, ifc.csr_raddr, ifc.csr_waddr, ifc.csr_wdata); end
    preload(12'h305, 32'h8000_0100);
    preload(12'h300, 32'h0000_0008);
    for (int i = 2; i < 8; i++) preload(addr_set[i], $urandom);
    @(negedge clk); rst = 1'b1; #1;
    checks++; if (ifc.req_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_early got=%0b need=0", ifc.req_ready); end
    @(posedge clk); #1;
    checks++; if (ifc.req_ready !== 1'b1) begin errors++; $display("FAIL rel_ready_edge got=%0b need=1", ifc.req_ready); end
  endtask

  task automatic test_csrrs;
    do_req(3'd1, 12'h300, 32'h80, 32'h1000);
    if (obs_ok) begin
      checks++; if (obs_lat !== 3) begin errors++; $display("FAIL rs_latency got=%0d need=3", obs_lat); end
      checks++; if (obs_data !== 32'h8) begin errors++; $display("FAIL rs_data got=%0h need=8", obs_data); end
      checks++; if ({obs_redir, obs_err} !== 2'b00) begin errors++; $display("FAIL rs_flags got=%0b%0b need=00", obs_redir, obs_err); end
      checks++; if (obs_nw !== 1 || obs_wc[0] !== 2 || obs_wa[0] !== 12'h300 || obs_wd[0] !== 32'h88) begin
        errors++; $display("FAIL rs_write got n=%0d cyc=%0d a=%0h d=%0h need 1/2/300/88", obs_nw, obs_wc[0], obs_wa[0], obs_wd[0]);
      end
      ack(0);
      checks++; if (ifc.resp_valid !== 1'b0 || ifc.req_ready !== 1'b1) begin errors++; $display("FAIL rs_after_ack got valid=%0b ready=%0b need 0/1", ifc.resp_valid, ifc.req_ready); end
    end
    refm[12'h300] = 32'h88;
  endtask

  task automatic test_csrrc_zero;
    int w0;
    w0 = wr_count;
    do_req(3'd2, 12'h300, 32'h0, 32'h1004);
    if (obs_ok) begin
      checks++; if (obs_data !== 32'h88) begin errors++; $display("FAIL rc0_data got=%0h need=88", obs_data); end
      checks++; if (obs_nw !== 0 || wr_count !== w0) begin errors++; $display("FAIL rc0_nowrite got=%0d writes need=0", wr_count - w0); end
      checks++; if (obs_lat !== 3) begin errors++; $display("FAIL rc0_latency got=%0d need=3", obs_lat); end
      ack(1);
    end
  endtask

  task automatic test_ecall;
    do_req(3'd3, 12'h123, 32'hdead, 32'h8000_0040);
    if (obs_ok) begin
      checks++; if (obs_lat !== 4) begin errors++; $display("FAIL ecall_latency got=%0d need=4", obs_lat); end
      checks++; if (obs_data !== 32'h8000_0100 || obs_redir !== 1'b1) begin errors++; $display("FAIL ecall_resp got data=%0h redir=%0b need 80000100/1", obs_data, obs_redir); end
      checks++; if (obs_nw !== 2 || obs_wc[0] !== 1 || obs_wa[0] !== 12'h342 || obs_wd[0] !== 32'hb) begin
        errors++; $display("FAIL ecall_cause got n=%0d cyc=%0d a=%0h d=%0h need 2/1/342/b", obs_nw, obs_wc[0], obs_wa[0], obs_wd[0]);
      end
      checks++; if (obs_wc[1] !== 2 || obs_wa[1] !== 12'h341 || obs_wd[1] !== 32'h8000_0040) begin
        errors++; $display("FAIL ecall_epc got cyc=%0d a=%0h d=%0h need 2/341/80000040", obs_wc[1], obs_wa[1], obs_wd[1]);
      end
      ack(0);
    end
    refm[12'h342] = 32'hb;
    refm[12'h341] = 32'h8000_0040;
  endtask

  task automatic test_mret;
    int w0;
    w0 = wr_count;
    do_req(3'd4, 12'h7AA, 32'h5, 32'h2000);
    if (obs_ok) begin
      checks++; if (obs_lat !== 2) begin errors++; $display("FAIL mret_latency got=%0d need=2", obs_lat); end
      checks++; if (obs_data !== 32'h8000_0040 || obs_redir !== 1'b1) begin errors++; $display("FAIL mret_resp got data=%0h redir=%0b need 80000040/1", obs_data, obs_redir); end
      checks++; if (wr_count !== w0) begin errors++; $display("FAIL mret_nowrite got=%0d writes need=0", wr_count - w0); end
      ack(0);
    end
  endtask

  task automatic test_reserved_hold;
    int w0;
    logic [31:0] d0;
    w0 = wr_count;
    do_req(3'd6, 12'h300, 32'hffff_ffff, 32'h3000);
    if (obs_ok) begin
      d0 = obs_data;
      checks++; if (obs_lat !== 1) begin errors++; $display("FAIL rsv_latency got=%0d need=1", obs_lat); end
      checks++; if (obs_err !== 1'b1 || obs_redir !== 1'b0) begin errors++; $display("FAIL rsv_flags got err=%0b redir=%0b need 1/0", obs_err, obs_redir); end
      for (int i = 0; i < 5; i++) begin
        @(posedge clk); #1;
        checks++;
        if (ifc.resp_valid !== 1'b1 || ifc.resp_err !== 1'b1 || ifc.resp_data !== d0 || ifc.req_ready !== 1'b0) begin
          errors++; $display("FAIL rsv_hold%0d got valid=%0b err=%0b data=%0h ready=%0b need 1/1/%0h/0", i, ifc.resp_valid, ifc.resp_err, ifc.resp_data, ifc.req_ready, d0);
        end
      end
      checks++; if (wr_count !== w0) begin errors++; $display("FAIL rsv_nowrite got=%0d writes need=0", wr_count - w0); end
      ack(0);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    @(negedge clk);
    ifc.req_valid = 1'b1; ifc.req_op = 3'd3; ifc.req_addr = '0; ifc.req_src = '0; ifc.req_pc = 32'h1234_5678;
    n = 0;
    while (!ifc.req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    ifc.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (ifc.csr_wen !== 1'b1 || ifc.csr_waddr !== 12'h341) begin errors++; $display("FAIL mid_in_epc got wen=%0b wa=%0h need 1/341", ifc.csr_wen, ifc.csr_waddr); end
    rst = 1'b0; #1;
    checks++; if ({ifc.csr_wen, ifc.csr_raddr, ifc.csr_waddr, ifc.csr_wdata} !== 57'h0) begin errors++; $display("FAIL mid_csr_zero got wen=%0b ra=%0h wa=%0h wd=%0h need 0", ifc.csr_wen, ifc.csr_raddr, ifc.csr_waddr, ifc.csr_wdata); end
    checks++; if ({ifc.req_ready, ifc.resp_valid, ifc.resp_redirect, ifc.resp_err, ifc.resp_data} !== 36'h0) begin errors++; $display("FAIL mid_resp_zero got ready=%0b valid=%0b data=%0h need 0", ifc.req_ready, ifc.resp_valid, ifc.resp_data); end
    repeat (3) @(posedge clk); #1;
    refm[12'h342] = 32'hb;
    checks++; if (mem[12'h341] !== refm[12'h341] || mem[12'h342] !== 32'hb) begin errors++; $display("FAIL mid_files got mepc=%0h mcause=%0h need %0h/b", mem[12'h341], mem[12'h342], refm[12'h341]); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (ifc.req_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_ready got=%0b need=1", ifc.req_ready); end
    do_req(3'd0, 12'h342, 32'h55, 32'h4000);
    if (obs_ok) begin
      checks++; if (obs_data !== 32'hb) begin errors++; $display("FAIL mid_rw_data got=%0h need=b", obs_data); end
      ack(0);
    end
    refm[12'h342] = 32'h55;
  endtask

  task automatic test_random;
    logic [2:0]  op;
    logic [11:0] a;
    logic [31:0] s, p, old, exp_data;
    int          exp_lat, exp_nw, w0, r;
    logic        exp_redir, exp_err;
    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      if (r == 6)      op = 3'd3;
      else if (r == 7) op = 3'd4;
      else if (r == 8) op = 3'(5 + $urandom_range(0, 2));
      else             op = 3'($urandom_range(0, 2));
      a = addr_set[$urandom_range(0, 7)];
      s = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      p = {$urandom, 2'b00} >> 2 << 2;
      exp_redir = 1'b0; exp_err = 1'b0; exp_nw = 0; exp_data = 32'h0;
      if (op <= 3'd2) begin
        old = refm[a]; exp_data = old; exp_lat = 3;
        if (op == 3'd0 || s != 0) begin
          exp_nw = 1;
          refm[a] = (op == 3'd0) ? s : (op == 3'd1) ? (old | s) : (old & ~s);
        end
      end else if (op == 3'd3) begin
        refm[12'h342] = 32'hb; refm[12'h341] = p;
        exp_data = refm[12'h305]; exp_lat = 4; exp_nw = 2; exp_redir = 1'b1;
      end else if (op == 3'd4) begin
        exp_data = refm[12'h341]; exp_lat = 2; exp_redir = 1'b1;
      end else begin
        exp_lat = 1; exp_err = 1'b1;
      end
      w0 = wr_count;
      do_req(op, a, s, p);
      if (!obs_ok) continue;
      checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL rnd%0d_latency op=%0d got=%0d need=%0d", t, op, obs_lat, exp_lat); end
      checks++; if ({obs_redir, obs_err} !== {exp_redir, exp_err}) begin errors++; $display("FAIL rnd%0d_flags op=%0d got=%0b%0b need=%0b%0b", t, op, obs_redir, obs_err, exp_redir, exp_err); end
      checks++; if (wr_count - w0 !== exp_nw) begin errors++; $display("FAIL rnd%0d_writes op=%0d got=%0d need=%0d", t, op, wr_count - w0, exp_nw); end
      if (!exp_err) begin
        checks++; if (obs_data !== exp_data) begin errors++; $display("FAIL rnd%0d_data op=%0d a=%0h got=%0h need=%0h", t, op, a, obs_data, exp_data); end
      end
      checks++; if (mem[a] !== refm[a] || mem[12'h341] !== refm[12'h341]) begin
        errors++; $display("FAIL rnd%0d_file a=%0h got=%0h/%0h need=%0h/%0h", t, a, mem[a], mem[12'h341], refm[a], refm[12'h341]);
      end
      ack($urandom_range(0, 3));
    end
  endtask

  initial begin
    ifc.req_valid = 1'b0; ifc.req_op = '0; ifc.req_addr = '0; ifc.req_src = '0;
    ifc.req_pc = '0; ifc.resp_ready = 1'b0;
    test_reset;
    test_csrrs;
    test_csrrc_zero;
    test_ecall;
    test_mret;
    test_reserved_hold;
    test_reset_mid;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/csr_access_ctrl.md
Name: csr_access_ctrl

Overview:
- Sequencer between the execute stage and the 4096-entry CSR register file.
- The CSR file has one combinational read port and one synchronous write port.
- This block turns CSR instructions (CSRRW/CSRRS/CSRRC), ECALL and MRET into ordered read/write cycles on that file, using valid/ready handshakes on both request and response.
- It replaces the file's built-in dual-write trap path: all trap updates go through the single write port, one register per cycle.

Parameters:
- ADDR_WIDTH, 12, CSR address width.
- DATA_WIDTH, 32, CSR data width.
- MTVEC_ADDR, 12'h305, trap vector CSR.
- MEPC_ADDR, 12'h341, exception PC CSR.
- MCAUSE_ADDR, 12'h342, trap cause CSR.
- ECALL_CAUSE, 32'h0000000b, value written to mcause on ECALL.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  3  0=CSRRW, 1=CSRRS, 2=CSRRC, 3=ECALL, 4=MRET, 5..7 reserved.
- req_addr  in  ADDR_WIDTH  target CSR (CSR ops only).
- req_src  in  DATA_WIDTH  rs1/zimm operand.
- req_pc  in  32  PC of the instruction.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  DATA_WIDTH  old CSR value (CSR ops), mtvec (ECALL), mepc (MRET).
- resp_redirect  out  1  resp_data is a new PC (ECALL/MRET).
- resp_err  out  1  reserved op; no CSR was modified.
- csr_raddr  out  ADDR_WIDTH  CSR file read address.
- csr_rdata  in  DATA_WIDTH  CSR file read data, combinational from csr_raddr.
- csr_wen  out  1  CSR file write enable.
- csr_waddr  out  ADDR_WIDTH  CSR file write address.
- csr_wdata  out  DATA_WIDTH  CSR file write data.

Behaviour:
- States: IDLE, READ, WRITE, TRAP_CAUSE, TRAP_EPC, TRAP_VEC, RESP.
- Reset (rst low, asynchronous):
  - state=IDLE.
  - req_ready=0, resp_valid=0, resp_data=0, resp_redirect=0, resp_err=0.
  - csr_wen=0, csr_raddr=0, csr_waddr=0, csr_wdata=0.
  - Latched op/addr/src/pc cleared.
- After reset release, req_ready rises on the first clk edge. req_ready=1 only in IDLE.
- Accept: req_valid && req_ready at an edge.
  - Latch op, addr, src, pc.
  - Deassert req_ready.
  - Next state depends on op: READ for 0/1/2/4, TRAP_CAUSE for 3, RESP with resp_err=1 for 5..7.
- csr_raddr and csr_wen/csr_waddr/csr_wdata are decoded from state and latched fields. csr_wen=1 only in WRITE, TRAP_CAUSE and TRAP_EPC.
- READ (1 cycle):
  - csr_raddr = latched addr, or MEPC_ADDR for MRET.
  - Capture csr_rdata into old_r at the edge.
  - Next state: WRITE for CSR ops, RESP for MRET.
- WRITE (1 cycle): csr_waddr=addr.
  - CSRRW: wdata = src.
  - CSRRS: wdata = old_r | src.
  - CSRRC: wdata = old_r & ~src.
  - For CSRRS/CSRRC with src==0, csr_wen stays 0 (no side-effect write).
  - Next state: RESP.
- ECALL sequence:
  - TRAP_CAUSE: write ECALL_CAUSE to MCAUSE_ADDR.
  - TRAP_EPC: write latched pc to MEPC_ADDR.
  - TRAP_VEC: csr_raddr=MTVEC_ADDR; capture csr_rdata into old_r.
  - Next state: RESP.
- RESP:
  - resp_valid=1, resp_data=old_r.
  - resp_redirect=1 for ECALL/MRET.
  - resp_err=1 for reserved ops.
  - Outputs hold stable until resp_valid && resp_ready at an edge, then go to IDLE with req_ready=1 the following cycle.
  - A new request is never accepted in the same cycle as a response handshake.
- Latency, counting the accept edge as cycle 0:
  - CSR op: resp_valid in cycle 3.
  - MRET: cycle 2.
  - ECALL: cycle 4.
  - Reserved op: cycle 1.
- Read-after-write: CSRRW on an address written by the previous ECALL sees the updated value, since write and read occur in different cycles.
- Reset mid-sequence aborts immediately with no further writes. If reset hits between TRAP_CAUSE and TRAP_EPC, the result (mcause updated, mepc stale) is the defined behaviour.
- Inputs are ignored outside IDLE. req_* changes while busy have no effect.

Test Plan:
- CSR file preloaded with mtvec=0x80000100, csr 0x300=0x0000_0008. CSRRS addr 0x300, src=0x80 -> write 0x88 to 0x300 in cycle 2; resp_data=0x8 in cycle 3; redirect=0.
- CSRRC addr 0x300, src=0 -> csr_wen never asserts; resp_data=0x88.
- ECALL pc=0x80000040 -> cycle 1 writes mcause=0xb, cycle 2 writes mepc=0x80000040; resp_data=0x80000100, redirect=1 in cycle 4.
- MRET right after ECALL -> resp_data=0x80000040, redirect=1 in cycle 2; no write.
- req_op=6 -> resp_err=1 in cycle 1; no write. Hold resp_ready=0 for 5 cycles -> resp_* stable and req_ready=0 throughout.
- Assert rst during TRAP_EPC -> outputs zero immediately, mepc unchanged. After release, req_ready=1 on the first edge and CSRRW addr 0x342 returns 0xb.
